input_conditioner: RTL and testbench

Parametrised multi-channel switch/button conditioner: the next generation of the single-channel reset and step-clock debouncers that sit between the board switches and the CPU datapath. Each channel synchronises a raw input, qualifies it with a stability counter, and produces a clean level plus one-cycle rise and fall pulses. An optional per-channel auto-repeat mode lets a held step switch emit a train of step pulses. Instantiated once at top level on the board clock, feeding the reset, single-step and free-run controls of the CPU.

---
 rtl/input_conditioner.sv | 129 ++++++++++++
 tb/tb_input_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Per-channel switch synchroniser, debouncer, edge pulses, auto-repeat
// Revision : 1.0
// ============================================================================
module input_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_COUNT  = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] step_pulse
);
    localparam int QW   = $clog2(STABLE_COUNT);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [QW-1:0] QUAL_LAST   = QW'(STABLE_COUNT - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic          s1_q, s2_q;
        logic          level_q, level_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          step_q, step_d;
        logic [QW-1:0] count_q, count_d;
        logic [RW-1:0] rc_q, rc_d;
        rep_state_e    state_q, state_d;
        logic          w_rep_fire;

        // Any cycle where the synchronised input agrees with the level clears the count.
        always_comb begin
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            count_d = '0;
            if (s2_q != level_q) begin
                if (count_q == QUAL_LAST) begin
                    level_d = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end

        // Keyed off the qualifying edge itself so the first repeat lands exactly
        // REPEAT_DELAY cycles after the rise pulse; leaving beats a due pulse.
        always_comb begin
            state_d    = state_q;
            rc_d       = rc_q;
            w_rep_fire = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise_d && repeat_en[c]) begin
                        state_d = ST_HOLD;
                        rc_d    = '0;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (fall_d || !repeat_en[c]) begin
                        state_d = ST_IDLE;
                        rc_d    = '0;
                    end else if (rc_q == ((state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
                        w_rep_fire = 1'b1;
                        rc_d       = '0;
                        state_d    = ST_REPEAT;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rc_d    = '0;
                end
            endcase
        end

        assign step_d = rise_d | w_rep_fire;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                step_q  <= 1'b0;
                count_q <= '0;
                rc_q    <= '0;
                state_q <= ST_IDLE;
            end else begin
                s1_q    <= raw_in[c];
                s2_q    <= s1_q;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                step_q  <= step_d;
                count_q <= count_d;
                rc_q    <= rc_d;
                state_q <= state_d;
            end
        end

        assign level_out[c]  = level_q;
        assign rise_pulse[c] = rise_q;
        assign fall_pulse[c] = fall_q;
        assign step_pulse[c] = step_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// Testbench for input_conditioner: vector table, corner sequences, randomized model check.
module tb_input_conditioner;
    localparam int CH = 2;
    localparam int SC = 4;
    localparam int RD = 6;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] raw_in, repeat_en;
    logic [CH-1:0] level_out, rise_pulse, fall_pulse, step_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .CHANNELS      (CH),
        .STABLE_COUNT  (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .repeat_en  (repeat_en),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .step_pulse (step_pulse)
    );

    typedef struct {
        logic [CH-1:0] raw, en, lvl, rise, fall, step;
    } vec_t;
    vec_t vecs[$];

    // Reference model: level flips once the last SC synchronised samples all
    // disagree with it; repeats are scheduled by age since the rise.
    logic          m_hist[CH][SC+2];
    logic [CH-1:0] m_level, m_rise, m_fall, m_step, m_active;
    int            m_age[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SC + 2; k++) m_hist[c][k] = 1'b0;
            m_age[c] = 0;
        end
        m_level = '0; m_rise = '0; m_fall = '0; m_step = '0; m_active = '0;
    endtask

    task automatic model_step();
        logic all_diff, rep;
        for (int c = 0; c < CH; c++) begin
            for (int k = SC + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = raw_in[c];
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            all_diff  = 1'b1;
            for (int k = 2; k < SC + 2; k++)
                if (m_hist[c][k] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) m_rise[c] = 1'b1;
                else            m_fall[c] = 1'b1;
            end
            rep = 1'b0;
            if (m_rise[c]) begin
                m_active[c] = repeat_en[c];
                m_age[c]    = 0;
            end else if (m_active[c]) begin
                if (m_fall[c] || !repeat_en[c]) begin
                    m_active[c] = 1'b0;
                end else begin
                    m_age[c] = m_age[c] + 1;
                    rep = (m_age[c] >= RD) && (((m_age[c] - RD) % RP) == 0);
                end
            end
            m_step[c] = m_rise[c] | rep;
        end
    endtask

    // Inputs only change 1 time unit after an edge, so the model sees what the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, level_out, rise_pulse, fall_pulse, step_pulse};
    endfunction

    task automatic add0(input logic r, input logic e, input logic l,
                        input logic ri, input logic f, input logic s);
        vec_t v;
        v.raw  = {1'b0, r};
        v.en   = {1'b0, e};
        v.lvl  = {1'b0, l};
        v.rise = {1'b0, ri};
        v.fall = {1'b0, f};
        v.step = {1'b0, s};
        vecs.push_back(v);
    endtask

    task automatic async_reset_check(input string name);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check(name, outs(), 32'd0);
        tick();
        tick();
        check({name, "_held"}, outs(), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic release_expect_rise(input string name);
        int first_rise = -1;
        int n_rise = 0;
        int n_fall = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (rise_pulse[0]) begin
                n_rise++;
                if (first_rise < 0) first_rise = k;
            end
            if (fall_pulse[0]) n_fall++;
        end
        check({name, "_rise_edge"}, first_rise, 6);
        check({name, "_rise_count"}, n_rise, 1);
        check({name, "_no_fall"}, n_fall, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_steps;
        int n_fall;
        int hold_left[CH];

        reset_n   = 1'b0;
        raw_in    = '1;
        repeat_en = '1;
        model_reset();
        for (int i = 0; i < 4; i++) tick();
        check("reset_outputs", outs(), 32'd0);
        raw_in    = '0;
        repeat_en = '0;
        tick();
        reset_n = 1'b1;

        // Clean step then release
        for (int j = 0; j < 16; j++)
            add0(j < 8, 1'b0, (j >= 5) && (j < 13), j == 5, j == 13, j == 5);
        // Short glitch
        for (int j = 0; j < 10; j++)
            add0(j < 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Bounce ending high, final transition at j=8
        for (int j = 0; j < 16; j++)
            add0((j < 10) ? ((j / 2) % 2 == 0) : 1'b1, 1'b0, j >= 13, j == 13, 1'b0, j == 13);
        for (int j = 0; j < 6; j++)
            add0(1'b0, 1'b0, j < 5, 1'b0, j == 5, 1'b0);
        // Auto-repeat held, then released with repeat still enabled
        for (int j = 0; j < 34; j++)
            add0(j < 26, 1'b1, (j >= 5) && (j < 31), j == 5, j == 31,
                 j inside {5, 11, 14, 17, 20, 23, 26, 29});
        // Repeat disabled: step mirrors rise
        for (int j = 0; j < 16; j++)
            add0(j < 8, 1'b0, (j >= 5) && (j < 13), j == 5, j == 13, j == 5);

        foreach (vecs[i]) begin
            raw_in    = vecs[i].raw;
            repeat_en = vecs[i].en;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {24'd0, vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].step});
        end

        // Drop repeat_en on the cycle the first repeat is due, later re-enable while held
        raw_in  = 2'b01;
        n_steps = 0;
        for (int k = 0; k < 40; k++) begin
            repeat_en = {1'b0, (k < 11) || (k >= 30)};
            tick();
            if (k == 5)  check("drop_rise_step", {30'd0, rise_pulse[0], step_pulse[0]}, 32'd3);
            if (k == 11) check("drop_due_no_pulse", step_pulse[0], 1'b0);
            if (k > 5 && step_pulse[0]) n_steps++;
        end
        check("drop_no_later_steps", n_steps, 0);
        check("drop_level_held", level_out, 2'b01);
        raw_in = 2'b00;
        n_fall = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (fall_pulse[0]) n_fall++;
        end
        check("drop_single_fall", n_fall, 1);

        // Async reset mid-qualification
        repeat_en = 2'b00;
        raw_in    = 2'b01;
        tick(); tick(); tick();
        async_reset_check("rst_mid_qual");
        release_expect_rise("rel_qual");
        raw_in = 2'b00;
        for (int k = 0; k < 8; k++) tick();

        // Async reset mid-REPEAT
        raw_in    = 2'b01;
        repeat_en = 2'b01;
        n_steps   = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (step_pulse[0]) n_steps++;
        end
        check("pre_rst_steps", n_steps, 2);
        async_reset_check("rst_mid_rep");
        repeat_en = 2'b00;
        release_expect_rise("rel_rep");
        raw_in = 2'b00;
        for (int k = 0; k < 8; k++) tick();

        // Randomized run against the model
        repeat_en = 2'b11;
        for (int c = 0; c < CH; c++) hold_left[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold_left[c] == 0) begin
                    int sel;
                    raw_in[c] = 1'($urandom_range(0, 1));
                    sel = $urandom_range(0, 9);
                    if (sel < 3)      hold_left[c] = $urandom_range(1, 3);
                    else if (sel < 8) hold_left[c] = $urandom_range(4, 12);
                    else              hold_left[c] = $urandom_range(15, 40);
                end
                hold_left[c]--;
                if ($urandom_range(0, 49) == 0) repeat_en[c] = ~repeat_en[c];
            end
            tick();
            check($sformatf("rand%0d", n), outs(), {24'd0, m_level, m_rise, m_fall, m_step});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
